// File: rtl/_regfile8_pkg.sv
// Shared constants and the register index type for the register file
// and its read-port multiplexers.
package constants;
   localparam int WORD_LENGTH   = 32;
   localparam int REG_COUNT     = 8;
   localparam int REG_ADDR_BITS = 3;

   typedef logic [REG_ADDR_BITS-1:0] reg_idx_t;
endpackage

// File: rtl/_regfile8_if.sv
// Bus between the issue/write-back logic (master) and the register file (slave).
interface _regfile8_if
   import constants::*;
#(
   parameter int n = WORD_LENGTH
);
   logic          we;
   reg_idx_t      waddr;
   logic [n-1:0]  wdata;
   logic          rsv_en;
   reg_idx_t      rsv_addr;
   reg_idx_t      raddr_a;
   reg_idx_t      raddr_b;
   logic [n-1:0]  rdata_a;
   logic [n-1:0]  rdata_b;
   logic          pend_a;
   logic          pend_b;
   logic [7:0]    pend_vec;
   logic [3:0]    pend_cnt;

   modport master (
      output we, waddr, wdata, rsv_en, rsv_addr, raddr_a, raddr_b,
      input  rdata_a, rdata_b, pend_a, pend_b, pend_vec, pend_cnt
   );

   modport slave (
      input  we, waddr, wdata, rsv_en, rsv_addr, raddr_a, raddr_b,
      output rdata_a, rdata_b, pend_a, pend_b, pend_vec, pend_cnt
   );
endinterface

// File: rtl/_regfile8_mux8.sv
// Eight-way word selector used by each register file read port.
module _mux8
   import constants::*;
#(
   parameter int n = WORD_LENGTH
) (
   input  logic [7:0][n-1:0] d,
   input  reg_idx_t          sel,
   output logic [n-1:0]      y
);
   assign y = d[sel];
endmodule

// File: rtl/_regfile8.sv
// Eight-entry register file with write-back bypass and a pending-write
// scoreboard whose population count is tracked incrementally.
module _regfile8
   import constants::*;
#(
   parameter int n       = WORD_LENGTH,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   _regfile8_if.slave   bus
);
   logic [7:0][n-1:0] regs;
   logic [7:0]        pend;
   logic [7:0]        pend_next;
   logic [3:0]        cnt;
   logic [3:0]        cnt_next;
   logic              wr_ok;
   logic              rsv_ok;
   logic              bit_set;
   logic              bit_clr;
   logic [n-1:0]      mux_a;
   logic [n-1:0]      mux_b;

   // With ZERO_R0, traffic to index 0 is dropped before it reaches any state.
   assign wr_ok  = bus.we     && !(ZERO_R0 && bus.waddr    == '0);
   assign rsv_ok = bus.rsv_en && !(ZERO_R0 && bus.rsv_addr == '0);

   // A reservation to the index being written back wins, so that case never clears.
   always_comb begin
      pend_next = pend;
      bit_set   = 1'b0;
      bit_clr   = 1'b0;
      if (wr_ok) begin
         pend_next[bus.waddr] = 1'b0;
         bit_clr = pend[bus.waddr] && !(rsv_ok && bus.rsv_addr == bus.waddr);
      end
      if (rsv_ok) begin
         pend_next[bus.rsv_addr] = 1'b1;
         bit_set = !pend[bus.rsv_addr];
      end
      cnt_next = cnt + {3'b000, bit_set} - {3'b000, bit_clr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
         pend <= '0;
         cnt  <= '0;
      end else begin
         if (wr_ok) regs[bus.waddr] <= bus.wdata;
         pend <= pend_next;
         cnt  <= cnt_next;
      end
   end

   _mux8 #(.n(n)) u_mux_a (.d(regs), .sel(bus.raddr_a), .y(mux_a));
   _mux8 #(.n(n)) u_mux_b (.d(regs), .sel(bus.raddr_b), .y(mux_b));

   // Reset also masks the bypass so reads are zero while rst_n is low.
   always_comb begin
      bus.rdata_a = '0;
      bus.rdata_b = '0;
      bus.pend_a  = 1'b0;
      bus.pend_b  = 1'b0;
      if (rst_n) begin
         if (!(ZERO_R0 && bus.raddr_a == '0)) begin
            bus.rdata_a = (bus.we && bus.waddr == bus.raddr_a) ? bus.wdata : mux_a;
            bus.pend_a  = pend[bus.raddr_a] && !(bus.we && bus.waddr == bus.raddr_a);
         end
         if (!(ZERO_R0 && bus.raddr_b == '0)) begin
            bus.rdata_b = (bus.we && bus.waddr == bus.raddr_b) ? bus.wdata : mux_b;
            bus.pend_b  = pend[bus.raddr_b] && !(bus.we && bus.waddr == bus.raddr_b);
         end
      end
   end

   assign bus.pend_vec = pend;
   assign bus.pend_cnt = cnt;

   cnt_matches_popcount: assert property (@(posedge clk) disable iff (!rst_n)
      bus.pend_cnt == 4'($countones(bus.pend_vec)));
   cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      bus.pend_cnt <= 4'd8);
endmodule

// File: tb/tb__regfile8.sv
// Directed bench for _regfile8: one instance with ZERO_R0=0 and one with
// ZERO_R0=1 share the stimulus and are compared each cycle to an array model.
module tb__regfile8;
   import constants::*;

   logic        clk;
   logic        rst_n;
   logic        we;
   reg_idx_t    waddr;
   logic [31:0] wdata;
   logic        rsv_en;
   reg_idx_t    rsv_addr;
   reg_idx_t    raddr_a;
   reg_idx_t    raddr_b;
   logic        cmp_en;

   int checks;
   int passes;

   logic [31:0] m_regs [2][8];
   logic        m_pend [2][8];

   _regfile8_if #(.n(32)) bus0 ();
   _regfile8_if #(.n(32)) bus1 ();

   assign bus0.we = we;         assign bus1.we = we;
   assign bus0.waddr = waddr;   assign bus1.waddr = waddr;
   assign bus0.wdata = wdata;   assign bus1.wdata = wdata;
   assign bus0.rsv_en = rsv_en; assign bus1.rsv_en = rsv_en;
   assign bus0.rsv_addr = rsv_addr; assign bus1.rsv_addr = rsv_addr;
   assign bus0.raddr_a = raddr_a;   assign bus1.raddr_a = raddr_a;
   assign bus0.raddr_b = raddr_b;   assign bus1.raddr_b = raddr_b;

   _regfile8 #(.n(32), .ZERO_R0(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   _regfile8 #(.n(32), .ZERO_R0(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // Model: index z selects the ZERO_R0 setting; index 0 is inert when z==1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int z = 0; z < 2; z++)
            for (int i = 0; i < 8; i++) begin
               m_regs[z][i] = '0;
               m_pend[z][i] = 1'b0;
            end
      end else begin
         for (int z = 0; z < 2; z++) begin
            if (we && !(z == 1 && waddr == 0)) begin
               m_regs[z][waddr] = wdata;
               m_pend[z][waddr] = 1'b0;
            end
            if (rsv_en && !(z == 1 && rsv_addr == 0)) m_pend[z][rsv_addr] = 1'b1;
         end
      end
   end

   function automatic logic [31:0] exp_rdata(input int z, input reg_idx_t a);
      if (!rst_n) return '0;
      if (z == 1 && a == 0) return '0;
      if (we && waddr == a) return wdata;
      return m_regs[z][a];
   endfunction

   function automatic logic exp_pend(input int z, input reg_idx_t a);
      if (!rst_n) return 1'b0;
      if (z == 1 && a == 0) return 1'b0;
      if (we && waddr == a) return 1'b0;
      return m_pend[z][a];
   endfunction

   function automatic logic [7:0] exp_vec(input int z);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_pend[z][i];
      return v;
   endfunction

   function automatic logic [3:0] exp_cnt(input int z);
      int c = 0;
      for (int i = 0; i < 8; i++) if (m_pend[z][i]) c++;
      return 4'(c);
   endfunction

   task automatic compare_dut(input int z, input logic [31:0] ra, input logic [31:0] rb,
                              input logic pa, input logic pb, input logic [7:0] pv,
                              input logic [3:0] pc);
      check($sformatf("dut%0d_rdata_a", z), ra, exp_rdata(z, raddr_a));
      check($sformatf("dut%0d_rdata_b", z), rb, exp_rdata(z, raddr_b));
      check($sformatf("dut%0d_pend_a", z), 32'(pa), 32'(exp_pend(z, raddr_a)));
      check($sformatf("dut%0d_pend_b", z), 32'(pb), 32'(exp_pend(z, raddr_b)));
      check($sformatf("dut%0d_pend_vec", z), 32'(pv), 32'(exp_vec(z)));
      check($sformatf("dut%0d_pend_cnt", z), 32'(pc), 32'(exp_cnt(z)));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         compare_dut(0, bus0.rdata_a, bus0.rdata_b, bus0.pend_a, bus0.pend_b,
                     bus0.pend_vec, bus0.pend_cnt);
         compare_dut(1, bus1.rdata_a, bus1.rdata_b, bus1.pend_a, bus1.pend_b,
                     bus1.pend_vec, bus1.pend_cnt);
      end
   end

   task automatic apply_stimulus(input logic w, input reg_idx_t wa, input logic [31:0] wd,
                                 input logic r, input reg_idx_t ra,
                                 input reg_idx_t a, input reg_idx_t b);
      we = w; waddr = wa; wdata = wd;
      rsv_en = r; rsv_addr = ra;
      raddr_a = a; raddr_b = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      cmp_en = 1'b1;
      rst_n  = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      check("reset_pend_vec", 32'(bus0.pend_vec), 32'h00);
      check("reset_pend_cnt", 32'(bus0.pend_cnt), 32'h0);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(7 - i));
         #2 check("reset_read", bus0.rdata_a, 32'h0);
         step();
      end

      apply_stimulus(1, 3, 32'hDEADBEEF, 0, 0, 3, 0);
      #2 check("bypass_r3", bus0.rdata_a, 32'hDEADBEEF);
      step();
      apply_stimulus(0, 0, 0, 0, 0, 3, 0);
      #2 check("stored_r3", bus0.rdata_a, 32'hDEADBEEF);
      step();

      apply_stimulus(0, 0, 0, 1, 1, 0, 0); step();
      apply_stimulus(0, 0, 0, 1, 2, 0, 0); step();
      apply_stimulus(0, 0, 0, 1, 5, 0, 0); step();
      apply_stimulus(0, 0, 0, 0, 0, 0, 2);
      #2 check("rsv_vec", 32'(bus0.pend_vec), 32'h26);
      check("rsv_cnt", 32'(bus0.pend_cnt), 32'd3);
      check("rsv_pend_b", 32'(bus0.pend_b), 32'd1);
      apply_stimulus(1, 2, 32'h0000_1234, 0, 0, 0, 2);
      #1 check("wb_pend_b", 32'(bus0.pend_b), 32'd0);
      step();
      apply_stimulus(0, 0, 0, 0, 0, 0, 2);
      #2 check("wb_vec", 32'(bus0.pend_vec), 32'h22);
      check("wb_cnt", 32'(bus0.pend_cnt), 32'd2);
      check("wb_data", bus0.rdata_b, 32'h0000_1234);

      apply_stimulus(1, 4, 32'h55, 1, 4, 4, 0);
      step();
      apply_stimulus(0, 0, 0, 0, 0, 4, 0);
      #2 check("same_edge_data", bus0.rdata_a, 32'h55);
      check("same_edge_pend_a", 32'(bus0.pend_a), 32'd1);
      check("same_edge_vec", 32'(bus0.pend_vec), 32'h32);
      check("same_edge_cnt", 32'(bus0.pend_cnt), 32'd3);
      step();

      apply_stimulus(1, 0, 32'hFF, 1, 0, 0, 0);
      #2 check("z_r0_no_bypass", bus1.rdata_a, 32'h0);
      check("r0_bypass", bus0.rdata_a, 32'hFF);
      step();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      #2 check("z_r0_read", bus1.rdata_a, 32'h0);
      check("z_r0_vec", 32'(bus1.pend_vec), 32'h32);
      check("z_r0_cnt", 32'(bus1.pend_cnt), 32'd3);
      check("r0_vec", 32'(bus0.pend_vec), 32'h33);
      check("r0_cnt", 32'(bus0.pend_cnt), 32'd4);
      check("r0_read", bus0.rdata_a, 32'hFF);
      step();

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(0, 0, 0, 1, reg_idx_t'(i), 0, 0);
         step();
      end
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      #2 check("all_cnt", 32'(bus0.pend_cnt), 32'd8);
      check("all_vec", 32'(bus0.pend_vec), 32'hFF);
      check("z_all_cnt", 32'(bus1.pend_cnt), 32'd7);
      check("z_all_vec", 32'(bus1.pend_vec), 32'hFE);
      step();

      // Reset lands between edges while a write-back to R6 is on the bus.
      apply_stimulus(1, 6, 32'h0000_ABCD, 0, 0, 6, 6);
      #2 rst_n = 1'b0;
      #1 check("rst_rdata_a", bus0.rdata_a, 32'h0);
      check("rst_pend_a", 32'(bus0.pend_a), 32'd0);
      check("rst_vec", 32'(bus0.pend_vec), 32'h00);
      check("rst_cnt", 32'(bus0.pend_cnt), 32'd0);
      check("z_rst_cnt", 32'(bus1.pend_cnt), 32'd0);
      @(posedge clk);
      #3 apply_stimulus(0, 0, 0, 0, 0, 6, 6);
      rst_n = 1'b1;
      step();
      #1 check("post_rst_r6", bus0.rdata_a, 32'h0);
      check("post_rst_vec", 32'(bus0.pend_vec), 32'h00);
      repeat (2) step();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
